// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and the SRAM slave FSM state type.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_BRESP,
        ST_RREAD,
        ST_RDATA
    } state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address, last-beat and per-beat error flag for one AXI burst.
// WRAP bursts are decoded only when AXI_SRAM_WRAP_BURST_EN is defined; otherwise WRAP is reserved.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    input  logic [7:0]  len,
    input  logic [7:0]  beat,
    output logic [31:0] next_addr,
    output logic        last,
    output logic        err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] incr;
    logic        size_err;
    logic        range_err;

    assign incr      = 32'd1 << size;
    assign size_err  = size > 3'd2;
    assign range_err = |addr[31:IDX_W+2];
    assign last      = beat == len;

`ifdef AXI_SRAM_WRAP_BURST_EN
    logic [31:0] wrap_mask;
    assign wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;
`endif

    always_comb begin
        next_addr = addr;
        err       = size_err | range_err;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = addr + incr;
`ifdef AXI_SRAM_WRAP_BURST_EN
            BURST_WRAP: begin
                // Stay inside the (len+1)<<size window that holds the aligned start.
                next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
                if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((addr & (incr - 32'd1)) != 32'd0)) begin
                    err = 1'b1;
                end
            end
`endif
            default:     err = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave over a single-port 32-bit word RAM, one transaction in flight at a time.
// Define AXI_SRAM_WRAP_BURST_EN to accept WRAP bursts (decoded in axi4_burst_addr_gen).
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int ID_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [31:0]     s_awaddr,
    input  logic [ID_W-1:0] s_awid,
    input  logic [7:0]      s_awlen,
    input  logic [2:0]      s_awsize,
    input  logic [1:0]      s_awburst,
    input  logic            s_wvalid,
    output logic            s_wready,
    input  logic [31:0]     s_wdata,
    input  logic [3:0]      s_wstrb,
    input  logic            s_wlast,
    output logic            s_bvalid,
    input  logic            s_bready,
    output logic [ID_W-1:0] s_bid,
    output logic [1:0]      s_bresp,
    input  logic            s_arvalid,
    output logic            s_arready,
    input  logic [31:0]     s_araddr,
    input  logic [ID_W-1:0] s_arid,
    input  logic [7:0]      s_arlen,
    input  logic [2:0]      s_arsize,
    input  logic [1:0]      s_arburst,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [31:0]     s_rdata,
    output logic [ID_W-1:0] s_rid,
    output logic [1:0]      s_rresp,
    output logic            s_rlast,
    output state_t          dbg_state
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t          state_q, state_d;
    logic            prio_wr_q, prio_wr_d;
    logic            run_q, run_d;
    logic [31:0]     addr_q, addr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d;
    logic            werr_q, werr_d;
    logic            bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] ram_idx;
    logic             ram_we;
    logic [31:0]      gen_next;
    logic             gen_last;
    logic             gen_err;
    logic             aw_go;
    logic             ar_go;
    logic             w_err;

    axi4_burst_addr_gen #(.DEPTH_WORDS(DEPTH_WORDS)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .len       (len_q),
        .beat      (beat_q),
        .next_addr (gen_next),
        .last      (gen_last),
        .err       (gen_err)
    );

    // Handshakes: a transfer happens on a rising edge with valid && ready both high. Address
    // readies may look at the valids (to arbitrate), but no valid output ever waits on a ready.
    assign aw_go   = run_q && (state_q == ST_IDLE) && s_awvalid && (!s_arvalid || prio_wr_q);
    assign ar_go   = run_q && (state_q == ST_IDLE) && s_arvalid && (!s_awvalid || !prio_wr_q);
    assign ram_idx = addr_q[IDX_W+1:2];
    assign w_err   = gen_err | (s_wlast & ~gen_last);

    assign s_awready = aw_go;
    assign s_arready = ar_go;
    assign s_wready  = state_q == ST_WDATA;
    assign s_bvalid  = bvalid_q;
    assign s_bid     = bid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rid     = rid_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = rlast_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        run_d     = 1'b1;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        burst_d   = burst_q;
        werr_d    = werr_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        ram_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aw_go) begin
                    addr_d  = s_awaddr;
                    id_d    = s_awid;
                    len_d   = s_awlen;
                    size_d  = s_awsize;
                    burst_d = s_awburst;
                    beat_d  = 8'd0;
                    werr_d  = 1'b0;
                    state_d = ST_WDATA;
                    if (s_arvalid) prio_wr_d = 1'b0;
                end else if (ar_go) begin
                    addr_d  = s_araddr;
                    id_d    = s_arid;
                    len_d   = s_arlen;
                    size_d  = s_arsize;
                    burst_d = s_arburst;
                    beat_d  = 8'd0;
                    state_d = ST_RREAD;
                    if (s_awvalid) prio_wr_d = 1'b1;
                end
            end
            ST_WDATA: begin
                if (s_wvalid) begin
                    ram_we = !gen_err && rst;
                    addr_d = gen_next;
                    beat_d = beat_q + 8'd1;
                    werr_d = werr_q | w_err;
                    if (s_wlast || gen_last) begin
                        state_d  = ST_BRESP;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = (werr_q | w_err) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            ST_BRESP: begin
                if (s_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RREAD: begin
                rvalid_d = 1'b1;
                rdata_d  = gen_err ? 32'd0 : mem[ram_idx];
                rresp_d  = gen_err ? RESP_SLVERR : RESP_OKAY;
                rid_d    = id_q;
                rlast_d  = gen_last;
                state_d  = ST_RDATA;
            end
            ST_RDATA: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = gen_next;
                        beat_d  = beat_q + 8'd1;
                        state_d = ST_RREAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            prio_wr_q <= 1'b1;
            run_q     <= 1'b0;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            werr_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            run_q     <= run_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            werr_q    <= werr_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // RAM array is never reset so its contents survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (s_wstrb[i]) mem[ram_idx][8*i +: 8] <= s_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed self-checking bench for axi4_sram_slave; WRAP expectations follow AXI_SRAM_WRAP_BURST_EN.
module tb_axi4_sram_slave;
    import axi4_pkg::*;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic [15:0] s_awid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_bvalid, s_bready;
    logic [15:0] s_bid;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [15:0] s_arid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [15:0] s_rid;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  exp_resp_q[$];

    axi4_sram_slave #(.DEPTH_WORDS(4096), .ID_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .dbg_state(dbg_state)
    );

    // Clock, cycle counter and watchdog.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [1:0] resp);
        exp_q.push_back(data);
        exp_resp_q.push_back(resp);
    endtask

    task automatic aw_req(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        bit ok = 1'b0;
        s_awaddr = addr; s_awid = id; s_awlen = len; s_awsize = size; s_awburst = burst;
        s_awvalid = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (s_awready) begin ok = 1'b1; break; end
        end
        check("aw_ready", 32'(ok), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
    endtask

    task automatic ar_req(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output int t);
        bit ok = 1'b0;
        s_araddr = addr; s_arid = id; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (s_arready) begin ok = 1'b1; break; end
        end
        check("ar_ready", 32'(ok), 32'd1);
        t = cyc;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 1'b0;
        s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb; s_wlast = last;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (s_wready) begin ok = 1'b1; break; end
        end
        check("w_ready", 32'(ok), 32'd1);
        @(posedge clk); #1;
        s_wvalid = 1'b0; s_wlast = 1'b0;
    endtask

    task automatic b_resp(input logic [15:0] id, input logic [1:0] resp);
        bit ok = 1'b0;
        s_bready = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (s_bvalid) begin ok = 1'b1; break; end
        end
        check("b_valid", 32'(ok), 32'd1);
        check("b_id", 32'(s_bid), 32'(id));
        check("b_resp", 32'(s_bresp), 32'(resp));
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    // Collects len+1 beats against the expected queues; beat stall_beat is held off for 5 cycles.
    task automatic r_beats(input logic [7:0] len, input logic [15:0] id, input int stall_beat, input int t_start);
        int t_prev;
        bit ok;
        logic [31:0] ed;
        logic [1:0] er;
        t_prev = t_start;
        for (int b = 0; b <= int'(len); b++) begin
            s_rready = (b != stall_beat);
            ok = 1'b0;
            for (int i = 0; i < TMO; i++) begin
                @(negedge clk);
                if (s_rvalid) begin ok = 1'b1; break; end
            end
            check("r_valid", 32'(ok), 32'd1);
            check("r_gap", 32'(cyc - t_prev), 32'd2);
            t_prev = cyc;
            ed = exp_q.pop_front();
            er = exp_resp_q.pop_front();
            check("r_data", s_rdata, ed);
            check("r_resp", 32'(s_rresp), 32'(er));
            check("r_id", 32'(s_rid), 32'(id));
            check("r_last", 32'(s_rlast), 32'(b == int'(len)));
            if (b == stall_beat) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("r_stall_valid", 32'(s_rvalid), 32'd1);
                    check("r_stall_data", s_rdata, ed);
                    check("r_stall_resp", 32'(s_rresp), 32'(er));
                    check("r_stall_id", 32'(s_rid), 32'(id));
                    check("r_stall_last", 32'(s_rlast), 32'(b == int'(len)));
                end
                s_rready = 1'b1;
                t_prev = cyc;
            end
            @(posedge clk); #1;
        end
        s_rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input logic [31:0] base, input logic [1:0] resp, input int early);
        aw_req(addr, id, len, size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            w_beat(base + 32'(b), strb, (b == int'(len)) || (b == early));
            if (b == early) break;
        end
        b_resp(id, resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
        int t;
        ar_req(addr, id, len, size, burst, t);
        r_beats(len, id, stall_beat, t);
    endtask

    initial begin
        rst = 1'b0;
        s_awvalid = 1'b1; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_bready = 1'b0;
        s_arvalid = 1'b1; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_bid", 32'(s_bid), 32'd0);
        check("rst_bresp", 32'(s_bresp), 32'd0);
        check("rst_rid", 32'(s_rid), 32'd0);
        check("rst_rresp", 32'(s_rresp), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_rlast", 32'(s_rlast), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Four-beat INCR write then read back, ids echoed.
        do_write(32'h10, 16'h1234, 8'd3, 3'd2, BURST_INCR, 4'hF, 32'hA0, RESP_OKAY, -1);
        for (int i = 0; i < 4; i++) push_exp(32'hA0 + 32'(i), RESP_OKAY);
        do_read(32'h10, 16'h0BEE, 8'd3, 3'd2, BURST_INCR, -1);

        // Byte-lane merge through write strobes.
        do_write(32'h20, 16'h0001, 8'd0, 3'd2, BURST_INCR, 4'hF, 32'h11223344, RESP_OKAY, -1);
        do_write(32'h20, 16'h0002, 8'd0, 3'd2, BURST_INCR, 4'h2, 32'h0000AA00, RESP_OKAY, -1);
        push_exp(32'h1122AA44, RESP_OKAY);
        do_read(32'h20, 16'h0003, 8'd0, 3'd2, BURST_INCR, -1);

        // Top-of-RAM boundary: last word fine, next word out of range.
        do_write(32'h3FFC, 16'h0004, 8'd0, 3'd2, BURST_INCR, 4'hF, 32'hDEADBEEF, RESP_OKAY, -1);
        do_write(32'h4000, 16'h0005, 8'd0, 3'd2, BURST_INCR, 4'hF, 32'h00000055, RESP_SLVERR, -1);
        push_exp(32'hDEADBEEF, RESP_OKAY);
        push_exp(32'h0, RESP_SLVERR);
        do_read(32'h3FFC, 16'h0006, 8'd1, 3'd2, BURST_INCR, -1);

        // Back-pressure on beat 3 of 4.
        for (int i = 0; i < 4; i++) push_exp(32'hA0 + 32'(i), RESP_OKAY);
        do_read(32'h10, 16'h0007, 8'd3, 3'd2, BURST_INCR, 2);

        // FIXED burst hits the same word every beat.
        do_write(32'h40, 16'h0008, 8'd1, 3'd2, BURST_FIXED, 4'hF, 32'hC0, RESP_OKAY, -1);
        push_exp(32'hC1, RESP_OKAY);
        push_exp(32'hC1, RESP_OKAY);
        do_read(32'h40, 16'h0009, 8'd1, 3'd2, BURST_FIXED, -1);

        // Oversized beat and reserved burst type.
        push_exp(32'h0, RESP_SLVERR);
        do_read(32'h10, 16'h000A, 8'd0, 3'd3, BURST_INCR, -1);
        push_exp(32'h0, RESP_SLVERR);
        push_exp(32'h0, RESP_SLVERR);
        do_read(32'h10, 16'h000B, 8'd1, 3'd2, 2'b11, -1);

        // Early WLAST on beat 2 of 4 ends the burst with an error.
        do_write(32'h60, 16'h000C, 8'd3, 3'd2, BURST_INCR, 4'hF, 32'hE0, RESP_SLVERR, 1);
        push_exp(32'hE0, RESP_OKAY);
        push_exp(32'hE1, RESP_OKAY);
        do_read(32'h60, 16'h000D, 8'd1, 3'd2, BURST_INCR, -1);

        // WRAP read starting mid-window.
        do_write(32'h30, 16'h000E, 8'd3, 3'd2, BURST_INCR, 4'hF, 32'hB0, RESP_OKAY, -1);
`ifdef AXI_SRAM_WRAP_BURST_EN
        push_exp(32'hB2, RESP_OKAY);
        push_exp(32'hB3, RESP_OKAY);
        push_exp(32'hB0, RESP_OKAY);
        push_exp(32'hB1, RESP_OKAY);
`else
        for (int i = 0; i < 4; i++) push_exp(32'h0, RESP_SLVERR);
`endif
        do_read(32'h38, 16'h000F, 8'd3, 3'd2, BURST_WRAP, -1);

        // Reset in the middle of a write burst.
        aw_req(32'h200, 16'h0010, 8'd3, 3'd2, BURST_INCR);
        w_beat(32'h77, 4'hF, 1'b0);
        check("mid_state_wdata", 32'(dbg_state), 32'(ST_WDATA));
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_wready", 32'(s_wready), 32'd0);
        check("mid_rst_bvalid", 32'(s_bvalid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Simultaneous AW/AR twice: write first, then read; RAM kept across reset.
        begin
            int t;
            s_awaddr = 32'h100; s_awid = 16'h0021; s_awlen = 8'd0; s_awsize = 3'd2; s_awburst = BURST_INCR;
            s_araddr = 32'h20;  s_arid = 16'h0022; s_arlen = 8'd0; s_arsize = 3'd2; s_arburst = BURST_INCR;
            s_awvalid = 1'b1; s_arvalid = 1'b1;
            @(negedge clk);
            check("arb1_awready", 32'(s_awready), 32'd1);
            check("arb1_arready", 32'(s_arready), 32'd0);
            @(posedge clk); #1;
            w_beat(32'h99, 4'hF, 1'b1);
            b_resp(16'h0021, RESP_OKAY);
            @(negedge clk);
            check("arb2_arready", 32'(s_arready), 32'd1);
            check("arb2_awready", 32'(s_awready), 32'd0);
            t = cyc;
            @(posedge clk); #1;
            s_arvalid = 1'b0;
            push_exp(32'h1122AA44, RESP_OKAY);
            r_beats(8'd0, 16'h0022, -1, t);
            aw_req(32'h100, 16'h0023, 8'd0, 3'd2, BURST_INCR);
            w_beat(32'h9A, 4'hF, 1'b1);
            b_resp(16'h0023, RESP_OKAY);
            push_exp(32'h9A, RESP_OKAY);
            do_read(32'h100, 16'h0024, 8'd0, 3'd2, BURST_INCR, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_sram_slave.md
AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: 32-bit words of on-chip RAM; power of two.
REQ-002 Parameter ID_W, default 16: AXI ID width.
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-low reset.
REQ-005 AW channel: s_awvalid in 1; s_awready out 1; s_awaddr in 32; s_awid in ID_W; s_awlen in 8; s_awsize in 3; s_awburst in 2.
REQ-006 W channel: s_wvalid in 1; s_wready out 1; s_wdata in 32; s_wstrb in 4; s_wlast in 1.
REQ-007 B channel: s_bvalid out 1; s_bready in 1; s_bid out ID_W; s_bresp out 2.
REQ-008 AR channel: s_arvalid in 1; s_arready out 1; s_araddr in 32; s_arid in ID_W; s_arlen in 8; s_arsize in 3; s_arburst in 2.
REQ-009 R channel: s_rvalid out 1; s_rready in 1; s_rdata out 32; s_rid out ID_W; s_rresp out 2; s_rlast out 1.

Function
REQ-010 Single-port RAM; one transaction at a time; FSM states IDLE, WDATA, BRESP, RREAD, RDATA.
REQ-011 IDLE: s_awready and s_arready are high only in IDLE; an accepted AW moves to WDATA; an accepted AR moves to RREAD.
REQ-012 AW and AR valid in the same IDLE cycle: grant alternates, starting with write after reset; the loser's ready stays low.
REQ-013 WDATA: s_wready is high; each beat writes the bytes enabled by s_wstrb at the current word address; the beat with s_wlast high, or beat number len+1, moves to BRESP.
REQ-014 BRESP: s_bvalid is high with the latched ID; return to IDLE on s_bready.
REQ-015 Read latency: RREAD issues the RAM read; s_rvalid asserts the next cycle (2 cycles after AR handshake); each further beat takes 2 cycles (no back-to-back beats).
REQ-016 RDATA: s_rdata, s_rid, s_rresp and s_rlast stay stable while s_rvalid && !s_rready; s_rlast is high on beat len+1; after the last beat, return to IDLE.
REQ-017 Beat address: next = addr + (1 << size) for INCR; unchanged for FIXED; word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-018 Error: size > 2, or any beat address >= 4*DEPTH_WORDS, gives resp SLVERR (2'b10) for that beat, a dropped write, and read data 0; the burst still completes with the full beat count.
REQ-019 Write resp is SLVERR if any beat errored, else OKAY; read resp is per beat.
REQ-020 Burst type 2'b11 (reserved) is treated as SLVERR for every beat.
REQ-021 Early s_wlast (before beat len+1) ends the burst with SLVERR; extra beats are not accepted.

Reset
REQ-022 With rst low on a clock edge: FSM goes to IDLE; all valid/ready outputs are 0; s_bid, s_bresp, s_rid, s_rresp, s_rdata and s_rlast are 0; the arbitration pointer is set to write.
REQ-023 Reset mid-burst abandons the transaction with no response; RAM contents are retained and not initialised.

Configuration
REQ-024 Macro AXI_SRAM_WRAP_BURST_EN compiled in: burst type WRAP (2'b10) is supported, with len in {1,3,7,15}, aligned start, wrap boundary (len+1)<<size, and SLVERR for an illegal len or a misaligned start.
REQ-025 Macro absent: WRAP is handled as reserved per REQ-020; no wrap logic is synthesised.

Structure
REQ-026 Shared package axi4_pkg holds the burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/EXOKAY/SLVERR/DECERR) and the FSM state enum.
REQ-027 One sub-module, axi4_burst_addr_gen: combinational next address from addr/size/burst/len, plus a range/alignment error flag; used by both the read and write paths.

Verification
REQ-028 AW addr 0x10, len 3, size 2, INCR, 4 beats of data 0xA0..0xA3 with strb 0xF, then AR same burst -> B OKAY with id echoed; R returns 0xA0..0xA3 with rlast on beat 4, each beat 2 cycles apart.
REQ-029 Write 0x11223344 to 0x20, then write strb 0x2 data 0x0000AA00 -> read of 0x20 returns 0x1122AA44.
REQ-030 AW and AR valid in the same cycle twice in a row after reset -> write granted first, read granted second.
REQ-031 AR at 4*DEPTH_WORDS-4, len 1 -> beat 1 OKAY with data, beat 2 SLVERR with data 0, rlast on beat 2.
REQ-032 Hold s_rready low for 5 cycles mid-burst -> R payload stable throughout; no beat lost.
REQ-033 With AXI_SRAM_WRAP_BURST_EN: WRAP len 3 at 0x38 -> beat addresses 0x38, 0x3C, 0x30, 0x34; without the macro -> all beats SLVERR.
